// File: rtl/hazard_ctrl_if.sv
// hazard_ctrl_if: pipeline-state inputs and stall/flush/HI-LO status outputs
// of the hazard controller, grouped for the pipeline-control boundary.
interface hazard_ctrl_if #(
  parameter int CNT_W = 32
);
  logic [4:0]       if_id_rs;
  logic [4:0]       if_id_rt;
  logic             if_id_uses_rt;
  logic             if_id_branch;
  logic             if_id_hilo;
  logic [4:0]       id_ex_rd;
  logic             id_ex_regwrite;
  logic             id_ex_memread;
  logic [4:0]       ex_mem_rd;
  logic             ex_mem_memread;
  logic             md_start;
  logic             md_is_div;
  logic             branch_taken;
  logic             stall_pc;
  logic             stall_if_id;
  logic             flush_id_ex;
  logic             flush_if_id;
  logic             md_busy;
  logic             md_done;
  logic [CNT_W-1:0] stall_count;

  modport master (
    output if_id_rs, if_id_rt, if_id_uses_rt,
    output if_id_branch, if_id_hilo,
    output id_ex_rd, id_ex_regwrite, id_ex_memread,
    output ex_mem_rd, ex_mem_memread,
    output md_start, md_is_div, branch_taken,
    input  stall_pc, stall_if_id, flush_id_ex,
    input  flush_if_id, md_busy, md_done,
    input  stall_count
  );

  modport slave (
    input  if_id_rs, if_id_rt, if_id_uses_rt,
    input  if_id_branch, if_id_hilo,
    input  id_ex_rd, id_ex_regwrite, id_ex_memread,
    input  ex_mem_rd, ex_mem_memread,
    input  md_start, md_is_div, branch_taken,
    output stall_pc, stall_if_id, flush_id_ex,
    output flush_if_id, md_busy, md_done,
    output stall_count
  );
endinterface

// File: rtl/hazard_ctrl.sv
// hazard_ctrl: load-use / ID-branch / HI-LO interlocks for the 5-stage pipe,
// with a HI/LO busy FSM and a saturating stall-cycle counter.
module hazard_ctrl #(
  parameter int MULT_CYCLES = 4,
  parameter int DIV_CYCLES  = 32,
  parameter int CNT_W       = 32
) (
  input logic        clk,
  input logic        reset,
  hazard_ctrl_if.slave hz
);
  localparam int MAXC =
    (DIV_CYCLES > MULT_CYCLES) ? DIV_CYCLES : MULT_CYCLES;
  localparam int CW = $clog2(MAXC) + 1;
  localparam logic [CW-1:0] DIV_LD  = CW'(DIV_CYCLES - 1);
  localparam logic [CW-1:0] MULT_LD = CW'(MULT_CYCLES - 1);

  localparam logic [0:0] IDLE = 1'b0;
  localparam logic [0:0] BUSY = 1'b1;

  logic [0:0]       state;
  logic [CW-1:0]    cnt;
  logic             done_q;
  logic [CNT_W-1:0] count_q;

  logic rs_ex, rt_ex, rs_mem, rt_mem;
  logic lu, br1, br2, md, stall;
  logic md_busy;

  assign md_busy = (state == BUSY);

  // register matches against EX/MEM destinations; $0 never matches
  always_comb begin
    rs_ex  = (hz.if_id_rs != 5'd0) && (hz.if_id_rs == hz.id_ex_rd);
    rt_ex  = hz.if_id_uses_rt && (hz.if_id_rt != 5'd0)
             && (hz.if_id_rt == hz.id_ex_rd);
    rs_mem = (hz.if_id_rs != 5'd0) && (hz.if_id_rs == hz.ex_mem_rd);
    rt_mem = hz.if_id_uses_rt && (hz.if_id_rt != 5'd0)
             && (hz.if_id_rt == hz.ex_mem_rd);
  end

  // stall sources; everything is held low while in reset
  always_comb begin
    lu    = hz.id_ex_memread && (rs_ex || rt_ex);
    br1   = hz.if_id_branch && hz.id_ex_regwrite && (rs_ex || rt_ex);
    br2   = hz.if_id_branch && hz.ex_mem_memread && (rs_mem || rt_mem);
    md    = hz.if_id_hilo && (md_busy || hz.md_start);
    stall = reset && (lu || br1 || br2 || md);
  end

  assign hz.stall_pc    = stall;
  assign hz.stall_if_id = stall;
  assign hz.flush_id_ex = stall;
  assign hz.flush_if_id = reset && hz.branch_taken && !stall;
  assign hz.md_busy     = md_busy;
  assign hz.md_done     = done_q;
  assign hz.stall_count = count_q;

  // HI/LO unit occupancy: load down-counter on start, pulse done on exit
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state  <= IDLE;
      cnt    <= '0;
      done_q <= 1'b0;
    end else begin
      done_q <= 1'b0;
      unique case (state)
        IDLE: begin
          if (hz.md_start) begin
            cnt   <= hz.md_is_div ? DIV_LD : MULT_LD;
            state <= BUSY;
          end
        end
        BUSY: begin
          if (cnt != '0) begin
            cnt <= cnt - 1'b1;
          end else begin
            state  <= IDLE;
            done_q <= 1'b1;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

  // count stalled cycles, sticking at all-ones
  always_ff @(posedge clk or negedge reset) begin
    if (!reset)
      count_q <= '0;
    else if (stall && (count_q != '1))
      count_q <= count_q + 1'b1;
  end
endmodule

// File: tb/tb_hazard_ctrl.sv
// tb_hazard_ctrl: directed vectors; expected responses are queued by the
// driver and compared by a negedge monitor.
module tb_hazard_ctrl;
  localparam int CW = 4;

  typedef struct {
    string      nm;
    logic [5:0] sig;
    logic [CW-1:0] cnt;
  } exp_t;

  logic clk = 1'b0;
  logic reset = 1'b0;
  int total = 0;
  int bad = 0;
  exp_t q[$];

  hazard_ctrl_if #(.CNT_W(CW)) bus ();

  hazard_ctrl #(
    .MULT_CYCLES(4),
    .DIV_CYCLES(32),
    .CNT_W(CW)
  ) dut (
    .clk(clk),
    .reset(reset),
    .hz(bus.slave)
  );

  always #5 clk = ~clk;

  // monitor: pop one expectation per cycle and compare
  always @(negedge clk) begin
    if (q.size() > 0) begin
      exp_t e;
      logic [5:0] act;
      e = q.pop_front();
      act = {bus.stall_pc, bus.stall_if_id, bus.flush_id_ex,
             bus.flush_if_id, bus.md_busy, bus.md_done};
      total++;
      if (act !== e.sig) begin
        bad++;
        $display("FAIL %s sig: got %b want %b", e.nm, act, e.sig);
      end
      total++;
      if (bus.stall_count !== e.cnt) begin
        bad++;
        $display("FAIL %s count: got %0d want %0d",
                 e.nm, bus.stall_count, e.cnt);
      end
    end
  end

  task automatic clr();
    bus.if_id_rs = 0; bus.if_id_rt = 0; bus.if_id_uses_rt = 0;
    bus.if_id_branch = 0; bus.if_id_hilo = 0;
    bus.id_ex_rd = 0; bus.id_ex_regwrite = 0; bus.id_ex_memread = 0;
    bus.ex_mem_rd = 0; bus.ex_mem_memread = 0;
    bus.md_start = 0; bus.md_is_div = 0; bus.branch_taken = 0;
  endtask

  task automatic step(input string nm, input logic [5:0] s,
                      input logic [CW-1:0] c);
    exp_t e;
    e.nm = nm; e.sig = s; e.cnt = c;
    q.push_back(e);
    @(posedge clk);
    #1;
  endtask

  localparam logic [5:0] NONE = 6'b000000;
  localparam logic [5:0] STL  = 6'b111000;
  localparam logic [5:0] FLS  = 6'b000100;
  localparam logic [5:0] BSY  = 6'b000010;
  localparam logic [5:0] BSTL = 6'b111010;
  localparam logic [5:0] DONE = 6'b000001;

  initial begin
    #100000;
    $display("FAIL watchdog: got timeout want finish");
    $fatal(1, "timeout");
  end

  initial begin
    clr();
    @(posedge clk); #1;
    bus.id_ex_memread = 1; bus.id_ex_rd = 8; bus.if_id_rs = 8;
    bus.branch_taken = 1;
    step("rst_forced", NONE, 0);
    clr();
    reset = 1'b1;
    step("post_rst", NONE, 0);

    bus.id_ex_memread = 1; bus.id_ex_rd = 8; bus.if_id_rs = 8;
    step("lu_rs", STL, 0);
    clr();
    step("lu_clear", NONE, 1);

    bus.id_ex_memread = 1; bus.id_ex_rd = 0; bus.if_id_rs = 0;
    step("lu_r0", NONE, 1);
    bus.id_ex_rd = 9; bus.if_id_rs = 1; bus.if_id_rt = 9;
    bus.if_id_uses_rt = 0;
    step("lu_rt_unused", NONE, 1);
    bus.if_id_uses_rt = 1;
    step("lu_rt_used", STL, 1);
    clr();

    bus.id_ex_memread = 1; bus.id_ex_regwrite = 1; bus.id_ex_rd = 5;
    bus.if_id_branch = 1; bus.if_id_rs = 5; bus.if_id_rt = 6;
    bus.if_id_uses_rt = 1; bus.branch_taken = 1;
    step("lw_beq_c1", STL, 2);
    bus.id_ex_memread = 0; bus.id_ex_regwrite = 0; bus.id_ex_rd = 0;
    bus.ex_mem_memread = 1; bus.ex_mem_rd = 5;
    step("lw_beq_c2", STL, 3);
    bus.ex_mem_memread = 0; bus.ex_mem_rd = 0;
    step("lw_beq_c3", FLS, 4);
    bus.branch_taken = 0;
    bus.id_ex_regwrite = 1; bus.id_ex_rd = 6;
    step("br1_rt", STL, 4);
    bus.if_id_branch = 0;
    step("br1_nobranch", NONE, 5);
    clr();

    bus.md_start = 1; bus.md_is_div = 0;
    step("mult_issue", NONE, 5);
    bus.md_start = 0; bus.if_id_hilo = 1;
    for (int i = 0; i < 4; i++)
      step("mult_busy", BSTL, CW'(5 + i));
    step("mult_done", DONE, 9);
    step("mult_idle", NONE, 9);
    clr();

    bus.if_id_hilo = 1; bus.md_start = 1; bus.md_is_div = 1;
    step("div_issue_hilo", STL, 9);
    clr();
    for (int i = 0; i < 9; i++)
      step("div_busy", BSY, 10);
    reset = 1'b0;
    step("div_abort", NONE, 0);
    step("div_rst_hold", NONE, 0);
    reset = 1'b1;
    for (int i = 0; i < 30; i++)
      step("div_no_done", NONE, 0);

    bus.id_ex_memread = 1; bus.id_ex_rd = 3; bus.if_id_rs = 3;
    for (int i = 0; i < 17; i++)
      step("sat_run", STL, (i > 15) ? CW'(15) : CW'(i));
    clr();
    step("sat_hold", NONE, 15);
    step("sat_hold2", NONE, 15);

    @(negedge clk);
    total++;
    if (q.size() != 0) begin
      bad++;
      $display("FAIL drain: got %0d want 0", q.size());
    end
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
